// File: rtl/dout_streamer.sv
// dout_streamer: unloads the output I/O region from byte-wide memory and streams it
// out as little-endian 32-bit words on a valid/ready interface.
module dout_streamer #(
    parameter int unsigned DOUT_ADDR   = 'h3F00,
    parameter int unsigned MAX_IO_SIZE = 256,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           numWords,
    output logic                  memRdEn,
    output logic [ADDR_WIDTH-1:0] memRdAddr,
    input  logic [7:0]            memRdData,
    output logic                  outValid,
    output logic [31:0]           outData,
    output logic                  outLast,
    input  logic                  outReady,
    output logic                  busy,
    output logic                  done
);
    localparam logic [31:0] MAX_WORDS = 32'(MAX_IO_SIZE / 4);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] count, count_nx, idx, idx_nx, clamped;
    logic [2:0]  k, k_nx;
    logic [1:0]  sel;
    logic        last;

    // numWords is the core's signed a0: non-positive means nothing to unload
    always_comb clamped = ($signed(numWords) <= 0) ? '0 :
                          ($signed(numWords) > $signed(MAX_WORDS)) ? MAX_WORDS : numWords;
    always_comb last = idx == count - 32'd1;
    always_comb sel = 2'(k - 3'd1);

    always_comb begin
        state_nx = state;
        count_nx = count;
        idx_nx   = idx;
        k_nx     = k;
        memRdEn  = 1'b0;
        case (state)
            IDLE: if (start) begin
                count_nx = clamped;
                idx_nx   = '0;
                k_nx     = '0;
                state_nx = (clamped == '0) ? DONE : FETCH;
            end
            // k = 0..3 issue reads; k = 4 only waits for the last byte to land
            FETCH: begin
                memRdEn  = k != 3'd4;
                k_nx     = (k == 3'd4) ? 3'd0 : k + 3'd1;
                state_nx = (k == 3'd4) ? PRESENT : FETCH;
            end
            PRESENT: if (outReady) begin
                idx_nx   = idx + 32'd1;
                state_nx = last ? DONE : FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb memRdAddr = memRdEn ? ADDR_WIDTH'(DOUT_ADDR) + ADDR_WIDTH'({idx, 2'b00}) + ADDR_WIDTH'(k) : '0;
    always_comb outValid = state == PRESENT;
    always_comb outLast  = outValid && last;
    always_comb busy     = state != IDLE;
    always_comb done     = state == DONE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            idx     <= '0;
            k       <= '0;
            outData <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            idx   <= idx_nx;
            k     <= k_nx;
            if (state == FETCH && k != 3'd0)
                outData[{sel, 3'b000} +: 8] <= memRdData;
        end
    end
endmodule

// File: doc/dout_streamer.md
# dout_streamer

Hardware unloader for the processor's output I/O region. It is the read-side counterpart of the input loader, which writes bytes into `DIN_ADDR` before reset. On a `start` pulse, issued when the core halts, this block reads 32-bit little-endian words from `DOUT_ADDR` in byte-wide main memory. It presents each word on a valid/ready stream, so the host or a UART bridge can collect program results without backdoor memory access.

## Interface
- `DOUT_ADDR`, default `'h3F00`: byte address of output word 0.
- `MAX_IO_SIZE`, default 256: output region size in bytes; must be a multiple of 4.
- `ADDR_WIDTH`, default 32: width of the memory address.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request, sampled only in IDLE.
- `numWords` input 32: word count, signed (the core's `a0`), sampled with `start`.
- `memRdEn` output 1: byte read strobe to main memory.
- `memRdAddr` output ADDR_WIDTH: byte read address.
- `memRdData` input 8: read data, valid exactly 1 cycle after `memRdEn`.
- `outValid` output 1: `outData` holds a word.
- `outData` output 32: assembled little-endian word.
- `outLast` output 1: high with the final word's `outValid`.
- `outReady` input 1: consumer accepts the word.
- `busy` output 1: high in any state except IDLE.
- `done` output 1: one-cycle pulse when the unload completes.

## Operation
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - On `start`, latch `count`:
    - 0 if `numWords` ≤ 0;
    - MAX_IO_SIZE/4 if `numWords` > MAX_IO_SIZE/4;
    - otherwise `numWords`.
  - Clear the word index `idx` to 0.
  - If `count` == 0, go to DONE; otherwise go to FETCH.
- FETCH:
  - Assert `memRdEn` for 4 consecutive cycles with addresses `DOUT_ADDR + 4*idx + k`, k = 0..3.
  - Capture the returned byte k into `outData[8k+7:8k]` one cycle after its read.
  - After byte 3 is captured, go to PRESENT.
  - `memRdAddr` is computed modulo 2^ADDR_WIDTH; no range check beyond the clamp.
- PRESENT:
  - `outValid` = 1; `outLast` = 1 iff `idx == count-1`.
  - On `outValid & outReady` at a clock edge: `idx++`.
  - Then go to DONE if that was the last word, else to FETCH.
  - `outData` and `outLast` stay stable while `outValid & !outReady`.
  - No memory reads occur in PRESENT.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored and has no side effects.
- `memRdEn` is 0 in every state except FETCH.
- `memRdAddr` is 0 whenever `memRdEn` is 0.
- Reset (asynchronous assert, any state):
  - State returns to IDLE.
  - All outputs go to 0: `memRdEn`, `memRdAddr`, `outValid`, `outData`, `outLast`, `busy`, `done`.
  - `count` and `idx` clear to 0.
  - An in-flight read response after deassertion is discarded.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycles 1–4: FETCH, `memRdEn` high, addresses base+0..base+3.
- Cycles 2–5: bytes captured.
- Cycle 6: `outValid` first high, registered output. Start-to-first-valid latency is 6 cycles.
- If the word transfers at cycle T:
  - the next word's first `memRdEn` is at T+1;
  - its `outValid` is at T+6.
  - With `outReady` tied high, throughput is 1 word per 6 cycles.
- Last word transferred at cycle T: `done` is high at T+1, `busy` is low at T+2.
- Clamped-to-zero count: `done` at cycle 1 and `busy` high during cycle 1 only; no reads and no `outValid`.
- `busy` rises the cycle after `start` is sampled and falls the cycle after `done`.
- Reset is asserted asynchronously. Deassertion must be synchronized externally to `clock`; the first `start` is sampled no earlier than the first edge after deassertion.

## Test plan
1. Memory from `'h3F00` = `01 00 00 00 FF FF FF FF 2A 00 00 00`; `numWords`=3; `outReady`=1 → `outData` = `'h00000001`, `'hFFFFFFFF`, `'h0000002A` at cycles 6, 12 and 18. `outLast` is high only on the third word; `done` is high at cycle 19.
2. `numWords`=1, `outReady`=0 for 10 cycles after `outValid`, then 1 → `outData` is held unchanged throughout, no `memRdEn` during the stall, and transfer happens on the first ready cycle. `done` follows 1 cycle later.
3. `numWords`=0, then `numWords`=-5 → no `memRdEn` and no `outValid` in either run; `done` is high at cycle 1 in each.
4. `numWords`=100 → exactly 64 words transferred, last read address `'h3FFF`, `outLast` on word 63.
5. A second `start` pulse mid-FETCH with `numWords`=7 → it is ignored, and the original count of 3 completes.
6. Reset asserted during PRESENT of word 1 → all outputs go to 0 immediately. A fresh `start` afterwards reads from `'h3F00` again, and the first `outValid` is 6 cycles after that `start`.
